irq_controller: RTL
===================

Name: irq_controller

Overview:
- Interrupt sequencer for the pipelined MIPS core; collects peripheral interrupt requests (timer, UART RX/TX, etc.) and drives the `IRQ` input of the main control unit.
- Latches requests as pending, selects one by priority and holds `IRQ` until the control unit redirects the PC to the handler.
- Masks further interrupts until the handler returns, then enforces a hold-off window before re-arming.

Parameters:
- N_SRC, 4, number of interrupt sources.
- CAUSE_W, 2, width of cause index; must satisfy 2^CAUSE_W >= N_SRC.
- HOLDOFF, 2, cycles after handler return before a new IRQ may be raised; 0 allowed.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- irq_src  in  N_SRC  raw request lines; a rising edge sets the pending bit.
- irq_en  in  N_SRC  per-source enable mask.
- global_en  in  1  global interrupt enable.
- kernel_mode  in  1  PC[31] of current fetch; 1 suppresses new IRQs.
- irq_ack  in  1  control unit accepted the interrupt (PCSrc==4 with IF_Flush).
- irq_ret  in  1  handler return executed (jr $k0 in kernel mode).
- clr  in  N_SRC  software clear of pending bits.
- IRQ  out  1  registered interrupt request to the main control unit.
- cause  out  CAUSE_W  index of the source selected or being serviced.
- pending  out  N_SRC  pending bits.
- busy  out  1  high while in SERVICE or HOLDOFF.

Behaviour:
- Reset (reset==0 at clk edge):
  - State=IDLE.
  - IRQ=0, cause=0, pending=0, busy=0, hold-off counter=0.
  - Edge-detect history=0, so a source already high when reset releases registers one edge on the first cycle.
- Edge detect:
  - pending[i] is set when irq_src[i]==1 and the previous sample was 0.
  - clr[i] clears pending[i]. If set and clear occur in the same cycle, set wins.
- Eligible set: pending & irq_en, qualified by global_en==1 and kernel_mode==0.
- Selection: fixed priority, lowest index wins.
- State IDLE:
  - If the eligible set is nonzero, latch cause=selected index and go to ASSERT; IRQ=1 from the next cycle.
  - Latency: a rising edge sampled at cycle t gives pending at t+1 and IRQ at t+2.
- State ASSERT:
  - IRQ=1.
  - On irq_ack: clear pending[cause] (a new edge on the same source in that cycle keeps it set), go to SERVICE, IRQ=0 next cycle.
  - Without ack: if kernel_mode==1, global_en==0, irq_en[cause]==0 or clr[cause]==1, return to IDLE and drop IRQ; pending is retained except when cleared by clr.
  - Ack has priority over withdrawal in the same cycle.
- State SERVICE:
  - IRQ=0, busy=1, cause held.
  - New edges still set pending.
  - On irq_ret: load counter=HOLDOFF and go to HOLDOFF, or go straight to IDLE if HOLDOFF==0.
- State HOLDOFF:
  - busy=1; counter decrements each cycle.
  - Go to IDLE in the cycle after the counter reaches 1, so exactly HOLDOFF cycles are spent here.
- Ignored inputs: irq_ack outside ASSERT; irq_ret outside SERVICE.
- Reset mid-operation returns to the reset values immediately, regardless of state.
- IRQ never rises while kernel_mode==1, and never rises in SERVICE or HOLDOFF.

Optional Feature:
- Macro: IRQ_PRIORITY_RR_EN.
- Defined:
  - Selection is round-robin: a pointer is set to (serviced cause + 1) mod N_SRC on each irq_ack.
  - Search starts at the pointer. Pointer resets to 0.
- Undefined: fixed priority, lowest index wins; no pointer register.

Test Plan (N_SRC=4, HOLDOFF=2):
1. Reset then idle: reset=0 for 2 cycles, all inputs 0 → IRQ=0, pending=4'b0000, busy=0, cause=0.
2. Single request:
   - Stimulus: irq_en=4'b1111, global_en=1; pulse irq_src[2] at cycle t.
   - Response: pending=4'b0100 at t+1; IRQ=1 and cause=2 at t+2.
   - Then irq_ack at t+4 → IRQ=0 and pending=0 at t+5, busy=1.
3. Simultaneous sources:
   - Stimulus: edges on src[1] and src[3] in the same cycle; ack, ret, wait 2 cycles.
   - Response: cause=1 first; cause=3 raised after hold-off.
   - With IRQ_PRIORITY_RR_EN and a prior service of src[1]: src[1] and src[3] again → cause=3.
4. Kernel-mode suppression:
   - Stimulus: pending[0]=1, kernel_mode=1.
   - Response: IRQ stays 0; IRQ=1 two cycles after kernel_mode falls.
   - kernel_mode rising while in ASSERT → IRQ=0 next cycle, pending[0] still 1.
5. Hold-off:
   - Stimulus: edge on src[0] during SERVICE; irq_ret at cycle r.
   - Response: busy=1 through r+2; IRQ rises at r+4, cause=0.
6. Reset mid-service: reset=0 while in SERVICE with pending=4'b1010 → next cycle IRQ=0, busy=0, pending=0.

Source files
------------

// File: rtl/irq_controller_if.sv
// Interrupt controller signal bundle: peripheral request lines and control-unit handshake.
// Handshake: IRQ is a level request held high until irq_ack is sampled high in the same cycle;
// irq_ret marks handler completion and is only meaningful while busy is high in service.
interface irq_controller_if #(
  parameter int N_SRC   = 4,
  parameter int CAUSE_W = 2
);
  logic [N_SRC-1:0]   irq_src;
  logic [N_SRC-1:0]   irq_en;
  logic               global_en;
  logic               kernel_mode;
  logic               irq_ack;
  logic               irq_ret;
  logic [N_SRC-1:0]   clr;
  logic               IRQ;
  logic [CAUSE_W-1:0] cause;
  logic [N_SRC-1:0]   pending;
  logic               busy;

  modport master (
    output irq_src, irq_en, global_en, kernel_mode, irq_ack, irq_ret, clr,
    input  IRQ, cause, pending, busy
  );

  modport slave (
    input  irq_src, irq_en, global_en, kernel_mode, irq_ack, irq_ret, clr,
    output IRQ, cause, pending, busy
  );
endinterface

// File: rtl/irq_controller.sv
// Interrupt sequencer: edge-latched pending bits, priority select, IRQ hold until ack, hold-off after return.
// Define IRQ_PRIORITY_RR_EN for round-robin selection instead of fixed lowest-index priority.
module irq_controller #(
  parameter int N_SRC   = 4,
  parameter int CAUSE_W = 2,
  parameter int HOLDOFF = 2
) (
  input  logic        clk,
  input  logic        reset,
  irq_controller_if.slave bus,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  localparam int CNT_W = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

  state_t             state, state_n;
  logic [N_SRC-1:0]   src_q;
  logic [N_SRC-1:0]   pending_q, pending_n;
  logic [N_SRC-1:0]   rise, eligible, clr_mask;
  logic [CAUSE_W-1:0] cause_q, cause_n;
  logic [CAUSE_W-1:0] sel;
  logic               sel_vld;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic               irq_q;
`ifdef IRQ_PRIORITY_RR_EN
  logic [CAUSE_W-1:0] ptr_q, ptr_n;
`endif

  assign rise     = bus.irq_src & ~src_q;
  assign eligible = pending_q & bus.irq_en & {N_SRC{bus.global_en & ~bus.kernel_mode}};

  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
`ifdef IRQ_PRIORITY_RR_EN
    // Search wraps around starting just past the last serviced source.
    for (int k = 0; k < N_SRC; k++) begin
      if (!sel_vld && eligible[(int'(ptr_q) + k) % N_SRC]) begin
        sel     = CAUSE_W'((int'(ptr_q) + k) % N_SRC);
        sel_vld = 1'b1;
      end
    end
`else
    for (int k = N_SRC - 1; k >= 0; k--) begin
      if (eligible[k]) begin
        sel     = CAUSE_W'(k);
        sel_vld = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    state_n  = state;
    cause_n  = cause_q;
    cnt_n    = cnt_q;
    clr_mask = bus.clr;
`ifdef IRQ_PRIORITY_RR_EN
    ptr_n    = ptr_q;
`endif
    case (state)
      ST_IDLE: begin
        if (sel_vld) begin
          state_n = ST_ASSERT;
          cause_n = sel;
        end
      end
      ST_ASSERT: begin
        // Ack wins over any withdrawal condition seen in the same cycle.
        if (bus.irq_ack) begin
          state_n           = ST_SERVICE;
          clr_mask[cause_q] = 1'b1;
`ifdef IRQ_PRIORITY_RR_EN
          ptr_n = (cause_q == CAUSE_W'(N_SRC - 1)) ? '0 : cause_q + 1'b1;
`endif
        end else if (bus.kernel_mode || !bus.global_en ||
                     !bus.irq_en[cause_q] || bus.clr[cause_q]) begin
          state_n = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (bus.irq_ret) begin
          if (HOLDOFF == 0) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_HOLDOFF;
            cnt_n   = CNT_W'(HOLDOFF);
          end
        end
      end
      ST_HOLDOFF: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
    // A fresh edge overrides both software clear and the ack clear.
    pending_n = (pending_q & ~clr_mask) | rise;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      src_q     <= '0;
      pending_q <= '0;
      cause_q   <= '0;
      cnt_q     <= '0;
      irq_q     <= 1'b0;
`ifdef IRQ_PRIORITY_RR_EN
      ptr_q     <= '0;
`endif
    end else begin
      state     <= state_n;
      src_q     <= bus.irq_src;
      pending_q <= pending_n;
      cause_q   <= cause_n;
      cnt_q     <= cnt_n;
      irq_q     <= (state_n == ST_ASSERT);
`ifdef IRQ_PRIORITY_RR_EN
      ptr_q     <= ptr_n;
`endif
    end
  end

  assign bus.IRQ     = irq_q;
  assign bus.cause   = cause_q;
  assign bus.pending = pending_q;
  assign bus.busy    = (state == ST_SERVICE) || (state == ST_HOLDOFF);
  assign dbg_state   = state;

endmodule
